// File: rtl/scroll_pkg.sv
// Shared types for the scroll sequencer.
//   cmd_op_t : command opcodes carried on cmd_op
//   state_t  : controller sequencing states
package scroll_pkg;

  typedef enum logic [1:0] {
    CmdNop    = 2'd0,
    CmdSetPos = 2'd1,
    CmdSetVel = 2'd2,
    CmdHalt   = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StApply   = 2'd2
  } state_t;

endpackage

// File: rtl/offset_step.sv
// Combinational offset step for one axis: result = normalize(base + inc).
// Normalization is wrap modulo SIZE when SCROLL_WRAP_EN is defined,
// otherwise saturation to [0, SIZE-1].
// Ports:
//   base   : current offset or raw position operand (signed)
//   inc    : per-frame velocity, or zero for pure normalization (signed)
//   result : normalized offset in [0, SIZE-1]
module offset_step #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned SIZE  = 640
) (
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] inc,
  output logic signed [WIDTH-1:0] result
);

  localparam logic signed [WIDTH:0] SizeW = (WIDTH+1)'(SIZE);
  localparam logic signed [WIDTH:0] MaxW  = (WIDTH+1)'(SIZE - 1);

  logic signed [WIDTH:0] sum;
  logic signed [WIDTH:0] fixed;

  always_comb begin
    // One extra bit so base + inc can never overflow.
    sum = {base[WIDTH-1], base} + {inc[WIDTH-1], inc};
`ifdef SCROLL_WRAP_EN
    // Single correction step; operands are bounded so one is enough.
    if (sum[WIDTH]) begin
      fixed = sum + SizeW;
    end else if (sum >= SizeW) begin
      fixed = sum - SizeW;
    end else begin
      fixed = sum;
    end
`else
    if (sum[WIDTH]) begin
      fixed = '0;
    end else if (sum >= SizeW) begin
      fixed = MaxW;
    end else begin
      fixed = sum;
    end
`endif
    result = fixed[WIDTH-1:0];
  end

endmodule

// File: rtl/scroll_controller.sv
// Frame-synchronous scroll sequencer. Accepts position/velocity commands over
// a valid/ready handshake and commits them only at frame boundaries; in idle
// frames the offsets advance by the current velocity.
// Build option: SCROLL_WRAP_EN selects wrap-around (defined) or saturation.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   frame_start         : one-cycle pulse at start of vertical blanking
//   cmd_valid/cmd_ready : command handshake
//   cmd_op              : 0 NOP, 1 SET_POS, 2 SET_VEL, 3 HALT
//   cmd_dh, cmd_dv      : signed operands (position or velocity)
//   hoffset, voffset    : registered signed offsets
//   offset_update       : pulses in any cycle the offsets are written
module scroll_controller
  import scroll_pkg::*;
#(
  parameter int unsigned HWIDTH = 12,
  parameter int unsigned VWIDTH = 12,
  parameter int unsigned HSIZE  = 640,
  parameter int unsigned VSIZE  = 480
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic signed [HWIDTH-1:0] cmd_dh,
  input  logic signed [VWIDTH-1:0] cmd_dv,
  output logic signed [HWIDTH-1:0] hoffset,
  output logic signed [VWIDTH-1:0] voffset,
  output logic                     offset_update
);

  state_t                   state_q;
  cmd_op_t                  op_q;
  logic signed [HWIDTH-1:0] dh_q, hvel_q, hoffset_q;
  logic signed [VWIDTH-1:0] dv_q, vvel_q, voffset_q;
  logic                     update_q;
  logic                     ready_q;

  logic signed [HWIDTH-1:0] h_base, h_inc, h_step;
  logic signed [VWIDTH-1:0] v_base, v_inc, v_step;

  // The same steppers serve motion, SET_VEL (motion with the new velocity)
  // and SET_POS (normalize operand with zero increment).
  always_comb begin
    h_base = hoffset_q;
    v_base = voffset_q;
    h_inc  = hvel_q;
    v_inc  = vvel_q;
    if (state_q == StApply) begin
      if (op_q == CmdSetPos) begin
        h_base = dh_q;
        v_base = dv_q;
        h_inc  = '0;
        v_inc  = '0;
      end else if (op_q == CmdSetVel) begin
        h_inc = dh_q;
        v_inc = dv_q;
      end
    end
  end

  offset_step #(
    .WIDTH(HWIDTH),
    .SIZE (HSIZE)
  ) u_hstep (
    .base  (h_base),
    .inc   (h_inc),
    .result(h_step)
  );

  offset_step #(
    .WIDTH(VWIDTH),
    .SIZE (VSIZE)
  ) u_vstep (
    .base  (v_base),
    .inc   (v_inc),
    .result(v_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= CmdNop;
      dh_q      <= '0;
      dv_q      <= '0;
      hvel_q    <= '0;
      vvel_q    <= '0;
      hoffset_q <= '0;
      voffset_q <= '0;
      update_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      update_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          // Motion uses the old velocity even if a command is captured now.
          if (frame_start) begin
            hoffset_q <= h_step;
            voffset_q <= v_step;
            update_q  <= 1'b1;
          end
          if (cmd_valid && ready_q && (cmd_op_t'(cmd_op) != CmdNop)) begin
            op_q    <= cmd_op_t'(cmd_op);
            dh_q    <= cmd_dh;
            dv_q    <= cmd_dv;
            state_q <= StPending;
            ready_q <= 1'b0;
          end
        end
        StPending: begin
          if (frame_start) begin
            state_q <= StApply;
          end
        end
        StApply: begin
          unique case (op_q)
            CmdSetPos: begin
              hoffset_q <= h_step;
              voffset_q <= v_step;
              update_q  <= 1'b1;
            end
            CmdSetVel: begin
              hvel_q    <= dh_q;
              vvel_q    <= dv_q;
              hoffset_q <= h_step;
              voffset_q <= v_step;
              update_q  <= 1'b1;
            end
            CmdHalt: begin
              hvel_q <= '0;
              vvel_q <= '0;
            end
            default: ;
          endcase
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready     = ready_q;
  assign hoffset       = hoffset_q;
  assign voffset       = voffset_q;
  assign offset_update = update_q;

endmodule

// File: tb/tb_scroll_controller.sv
module tb_scroll_controller;

`ifdef SCROLL_WRAP_EN
  localparam int HA = 4;    // 636 + 8 wrapped
  localparam int VB = 478;  // 1 - 3 wrapped
`else
  localparam int HA = 639;
  localparam int VB = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame_start = 1'b0;
  logic               cmd_valid = 1'b0;
  logic [1:0]         cmd_op = 2'd0;
  logic signed [11:0] cmd_dh = '0;
  logic signed [11:0] cmd_dv = '0;
  logic               cmd_ready;
  logic signed [11:0] hoffset;
  logic signed [11:0] voffset;
  logic               offset_update;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       fs;
    logic       valid;
    logic [1:0] op;
    int         dh;
    int         dv;
    int         eh;
    int         ev;
    int         eu;
    int         er;
  } vec_t;

  vec_t vecs[$];

  scroll_controller #(
    .HWIDTH(12),
    .VWIDTH(12),
    .HSIZE (640),
    .VSIZE (480)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_dh       (cmd_dh),
    .cmd_dv       (cmd_dv),
    .hoffset      (hoffset),
    .voffset      (voffset),
    .offset_update(offset_update)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int eh, input int ev, input int eu,
                            input int er);
    check({tag, " hoffset"}, int'(hoffset), eh);
    check({tag, " voffset"}, int'(voffset), ev);
    check({tag, " offset_update"}, int'(offset_update), eu);
    check({tag, " cmd_ready"}, int'(cmd_ready), er);
  endtask

  task automatic add(input logic fs, input logic valid, input logic [1:0] op, input int dh,
                     input int dv, input int eh, input int ev, input int eu, input int er);
    vec_t v;
    v.fs = fs; v.valid = valid; v.op = op; v.dh = dh; v.dv = dv;
    v.eh = eh; v.ev = ev; v.eu = eu; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic fs, input logic valid, input logic [1:0] op, input int dh,
                       input int dv);
    frame_start = fs;
    cmd_valid   = valid;
    cmd_op      = op;
    cmd_dh      = 12'(dh);
    cmd_dv      = 12'(dv);
  endtask

  initial begin
    // Each row: inputs held for one cycle, outputs expected after that edge.
    // fs  vld op  dh   dv    eh   ev   upd rdy
    // SET_VEL (4,0) then three frames of motion
    add(0, 1, 2, 4,   0,    0,   0,   0,  0);
    add(0, 0, 0, 0,   0,    0,   0,   0,  0);
    add(1, 0, 0, 0,   0,    0,   0,   0,  0);
    add(0, 0, 0, 0,   0,    4,   0,   1,  1);
    add(0, 0, 0, 0,   0,    4,   0,   0,  1);
    add(1, 0, 0, 0,   0,    8,   0,   1,  1);
    add(0, 0, 0, 0,   0,    8,   0,   0,  1);
    add(1, 0, 0, 0,   0,    12,  0,   1,  1);
    add(0, 0, 0, 0,   0,    12,  0,   0,  1);
    // SET_POS 636, SET_VEL 8 -> wrap or saturate at the right edge
    add(0, 1, 1, 636, 0,    12,  0,   0,  0);
    add(1, 0, 0, 0,   0,    12,  0,   0,  0);
    add(0, 0, 0, 0,   0,    636, 0,   1,  1);
    add(0, 1, 2, 8,   0,    636, 0,   0,  0);
    add(1, 0, 0, 0,   0,    636, 0,   0,  0);
    add(0, 0, 0, 0,   0,    HA,  0,   1,  1);
    // SET_POS dv=1, SET_VEL dv=-3 -> wrap or saturate below zero
    add(0, 1, 1, 0,   1,    HA,  0,   0,  0);
    add(1, 0, 0, 0,   0,    HA,  0,   0,  0);
    add(0, 0, 0, 0,   0,    0,   1,   1,  1);
    add(0, 1, 2, 0,   -3,   0,   1,   0,  0);
    add(1, 0, 0, 0,   0,    0,   1,   0,  0);
    add(0, 0, 0, 0,   0,    0,   VB,  1,  1);
    // Reach velocity 2, hoffset 10
    add(0, 1, 1, 8,   0,    0,   VB,  0,  0);
    add(1, 0, 0, 0,   0,    0,   VB,  0,  0);
    add(0, 0, 0, 0,   0,    8,   0,   1,  1);
    add(0, 1, 2, 2,   0,    8,   0,   0,  0);
    add(1, 0, 0, 0,   0,    8,   0,   0,  0);
    add(0, 0, 0, 0,   0,    10,  0,   1,  1);
    // Handshake coincident with frame_start: old velocity moves this frame
    add(1, 1, 1, 100, 50,   12,  0,   1,  0);
    add(0, 0, 0, 0,   0,    12,  0,   0,  0);
    add(1, 0, 0, 0,   0,    12,  0,   0,  0);
    add(0, 0, 0, 0,   0,    100, 50,  1,  1);
    // HALT: no write at commit, then a zero-velocity frame still pulses update
    add(0, 1, 3, 0,   0,    100, 50,  0,  0);
    add(1, 0, 0, 0,   0,    100, 50,  0,  0);
    add(0, 0, 0, 0,   0,    100, 50,  0,  1);
    add(1, 0, 0, 0,   0,    100, 50,  1,  1);
    add(0, 0, 0, 0,   0,    100, 50,  0,  1);
    // NOP is accepted and discarded; ready stays high
    add(0, 1, 0, 5,   5,    100, 50,  0,  1);
    add(1, 0, 0, 0,   0,    100, 50,  1,  1);
    // frame_start during APPLY is ignored
    add(0, 1, 2, 1,   1,    100, 50,  0,  0);
    add(1, 0, 0, 0,   0,    100, 50,  0,  0);
    add(1, 0, 0, 0,   0,    101, 51,  1,  1);
    add(0, 0, 0, 0,   0,    101, 51,  0,  1);

    // Reset held for three cycles
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outs($sformatf("reset cycle %0d", i), 0, 0, 0, 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("after release", 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fs, vecs[i].valid, vecs[i].op, vecs[i].dh, vecs[i].dv);
      @(posedge clk);
      #1;
      check_outs($sformatf("vec %0d", i), vecs[i].eh, vecs[i].ev, vecs[i].eu, vecs[i].er);
    end

    // Reset while a SET_POS(200,0) is pending discards it
    drive(0, 1, 1, 200, 0);
    @(posedge clk);
    #1;
    check_outs("midrst capture", 101, 51, 0, 0);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_outs("midrst in reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("midrst release", 0, 0, 0, 1);
    // Velocity is zero, so frames rewrite 0 and never commit the lost command
    for (int f = 0; f < 2; f++) begin
      drive(1, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_outs($sformatf("midrst frame %0d", f), 0, 0, 1, 1);
      drive(0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_outs($sformatf("midrst frame %0d +1", f), 0, 0, 0, 1);
      @(posedge clk);
      #1;
      check_outs($sformatf("midrst frame %0d +2", f), 0, 0, 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scroll_controller.md
# scroll_controller

Frame-synchronous scroll sequencer that drives the signed `hoffset`/`voffset` inputs of the pixel-to-framebuffer address transformer. It accepts position and velocity commands over a valid/ready handshake and applies them only at frame boundaries, so the image never tears mid-frame. It sits between game logic and the VGA address path, and advances the offsets by a per-frame velocity with wrap-around or saturation.

## Interface
- `HWIDTH`, 12, horizontal coordinate and offset width
- `VWIDTH`, 12, vertical coordinate and offset width
- `HSIZE`, 640, horizontal extent in pixels; offset range is [0, HSIZE-1]
- `VSIZE`, 480, vertical extent in pixels; offset range is [0, VSIZE-1]
- `clk` input 1: system clock, single domain
- `rst_n` input 1: synchronous, active-low reset
- `frame_start` input 1: one-cycle pulse at the start of vertical blanking
- `cmd_valid` input 1: command offered
- `cmd_ready` output 1: controller can accept a command
- `cmd_op` input 2: 0 NOP, 1 SET_POS, 2 SET_VEL, 3 HALT
- `cmd_dh` input HWIDTH, signed horizontal operand (position or velocity)
- `cmd_dv` input VWIDTH, signed vertical operand
- `hoffset` output HWIDTH, signed registered horizontal offset
- `voffset` output VWIDTH, signed registered vertical offset
- `offset_update` output 1: one-cycle pulse when offsets are rewritten

## Operation
- Reset values: `hoffset`=0, `voffset`=0, `offset_update`=0, velocity (hvel, vvel)=0, state IDLE, `cmd_ready`=0 while `rst_n` is low.
- States:
  - IDLE: `cmd_ready`=1. Handshake on `cmd_valid & cmd_ready`; latch op and operands, then go to PENDING. A NOP is accepted and discarded, and the block stays in IDLE.
  - PENDING: `cmd_ready`=0. On `frame_start`, go to APPLY.
  - APPLY: single cycle. Commit the command, then return to IDLE.
- Commit rules:
  - SET_POS: offsets take the normalized operands. No motion is applied that frame.
  - SET_VEL: velocity takes the operands. Offsets advance by the new velocity that frame.
  - HALT: velocity becomes 0. No motion is applied.
- If `frame_start` arrives in IDLE, offsets advance by the current velocity. This includes the case where a handshake happens in the same cycle: the old velocity moves the offsets this frame, and the captured command commits at the next `frame_start`.
- A `frame_start` pulse that arrives during APPLY is ignored. Frames are assumed to be at least 3 cycles apart.
- Arithmetic:
  - Sum is computed at width+1 bits, signed.
  - Wrap and saturation behaviour are given in Configuration.
  - Velocity magnitude must be less than SIZE. Larger values are illegal, and the bench must not drive them.
- `offset_update` pulses in every cycle in which either offset register is written, including a write of an unchanged value.
- Reset mid-operation: a captured command is discarded, and all registers return to their reset values.

## Timing
- `hoffset`/`voffset` change exactly 1 cycle after a `frame_start` motion update, with `offset_update` high in that same cycle.
- A command commit lands 2 cycles after `frame_start` (PENDING→APPLY, then the register write).
- `cmd_ready` rises 1 cycle after `rst_n` deasserts, and 1 cycle after APPLY.
- Commands are never applied outside frame boundaries. Minimum command-to-effect latency is the next `frame_start` plus 2 cycles.

## Configuration
- `SCROLL_WRAP_EN` defined:
  - Each axis wraps modulo SIZE: if sum ≥ SIZE, subtract SIZE; if sum < 0, add SIZE.
  - SET_POS operands are normalized the same way. One correction step only, so operands must lie in (−SIZE, 2·SIZE).
- Undefined:
  - Each axis saturates to [0, SIZE−1]. This applies to both motion and SET_POS.
  - When a positive velocity saturates an axis, that axis's velocity stays unchanged.

## Structure
- Package `scroll_pkg`:
  - `cmd_op_t` enum (NOP, SET_POS, SET_VEL, HALT)
  - `state_t` enum (IDLE, PENDING, APPLY)
- Sub-module `offset_step`, parameterized by WIDTH and SIZE:
  - Combinational signed add plus wrap/saturate, selected by `SCROLL_WRAP_EN`.
  - Instantiated once per axis, and reused for SET_POS normalization with a zero increment.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release → offsets 0, `offset_update` 0, `cmd_ready`=1 on the first cycle after release.
- SET_VEL dh=4 dv=0, then 3 `frame_start` pulses → the commit frame moves `hoffset` to 4, then 8 and 12. Each change is accompanied by an `offset_update` pulse; `voffset` stays 0.
- SET_POS dh=636, then SET_VEL dh=8, then 1 `frame_start` → `hoffset`=4 with wrap, or 639 without wrap.
- SET_POS dv=1, then SET_VEL dv=−3, then `frame_start` → `voffset`=478 with wrap, or 0 without wrap.
- With velocity 2 and `hoffset` 10, drive a SET_POS(100,50) handshake in the same cycle as `frame_start` → `hoffset`=12 one cycle later; at the next `frame_start`, `hoffset`=100 and `voffset`=50 two cycles later.
- Pull `rst_n` low while PENDING holds SET_POS(200,0) → offsets 0, and no commit at later `frame_start` pulses.
